i2c_master_engine: RTL and testbench

//  Byte-level I2C master sequencer. Feeds the open-drain SDA/SCL pad stage
//  (pullups, sda_in/scl_in taps) from a simple command port. Generates

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_quarter_tick.sv | 28 ++
 rtl/i2c_master_engine.sv | 176 +++++++++++++++++
 tb/tb_i2c_master_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master engine: command encodings, FSM states
// and the quarter-bit index type.
package i2c_pkg;

  localparam logic [1:0] I2C_CMD_START = 2'd0;
  localparam logic [1:0] I2C_CMD_STOP  = 2'd1;
  localparam logic [1:0] I2C_CMD_WRITE = 2'd2;
  localparam logic [1:0] I2C_CMD_READ  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WBIT,
    ST_WACK,
    ST_RBIT,
    ST_RACK
  } state_t;

  typedef logic [1:0] quarter_t;

  // SCL is held low in the first and last quarter of every data/ack bit.
  function automatic logic data_scl_oe(input quarter_t q);
    return (q == 2'd0) || (q == 2'd3);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: pulses tick once every DIV clocks; clear restarts the
// count and hold freezes it (used for slave clock stretching).
module i2c_quarter_tick #(
  parameter int DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = !hold && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master_engine.sv
// Byte-level I2C master sequencer driving open-drain SDA/SCL enables.
// Optional slave clock stretching is enabled with `define I2C_CLOCK_STRETCH_EN.
module i2c_master_engine
  import i2c_pkg::*;
#(
  parameter int DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic       scl_oe
);

  state_t     state_q, state_d;
  quarter_t   quarter_q, quarter_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       rd_nack_q, rd_nack_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       scl_oe_q, scl_oe_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_nack_q, rsp_nack_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       accept;
  logic       tick;
  logic       step;
  logic       stretch_hold;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != ST_IDLE);
  assign step      = tick && (state_q != ST_IDLE);

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave holding SCL low after we released it freezes the bit timing.
  assign stretch_hold = (state_q != ST_IDLE) && (quarter_q == 2'd1) &&
                        !scl_oe_q && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stretch_hold  = 1'b0;
`endif

  i2c_quarter_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .hold (stretch_hold),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      quarter_q   <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      rd_nack_q   <= 1'b0;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      rd_nack_q   <= rd_nack_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Line enables are derived from the next state/quarter so they are
  // registered yet aligned with the quarter they belong to.
  always_comb begin
    state_d     = state_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    data_d      = data_q;
    rd_nack_d   = rd_nack_q;
    ack_d       = ack_q;
    rsp_valid_d = 1'b0;
    rsp_nack_d  = rsp_nack_q;
    rsp_data_d  = rsp_data_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        quarter_d = '0;
        bit_d     = 3'd7;
        data_d    = wr_data;
        rd_nack_d = rd_nack;
        case (cmd)
          I2C_CMD_START: state_d = ST_START;
          I2C_CMD_STOP:  state_d = ST_STOP;
          I2C_CMD_WRITE: state_d = ST_WBIT;
          default:       state_d = ST_RBIT;
        endcase
      end
    end else if (step) begin
      quarter_d = quarter_q + 2'd1;
      if (quarter_q == 2'd2) begin
        if (state_q == ST_RBIT) data_d = {data_q[6:0], sda_in};
        if (state_q == ST_WACK) ack_d = sda_in;
      end
      if (quarter_q == 2'd3) begin
        case (state_q)
          ST_WBIT, ST_RBIT: begin
            if (bit_q == 3'd0) state_d = (state_q == ST_WBIT) ? ST_WACK : ST_RACK;
            else bit_d = bit_q - 3'd1;
          end
          ST_WACK, ST_RACK: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_nack_d  = (state_q == ST_WACK) ? ack_q : rd_nack_q;
            if (state_q == ST_RACK) rsp_data_d = data_q;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    case (state_d)
      ST_START: begin
        sda_oe_d = (quarter_d >= 2'd2);
        scl_oe_d = (quarter_d == 2'd3);
      end
      ST_STOP: begin
        sda_oe_d = (quarter_d <= 2'd1);
        scl_oe_d = (quarter_d == 2'd0);
      end
      ST_WBIT: begin
        sda_oe_d = ~data_d[bit_d];
        scl_oe_d = data_scl_oe(quarter_d);
      end
      ST_WACK, ST_RBIT: begin
        sda_oe_d = 1'b0;
        scl_oe_d = data_scl_oe(quarter_d);
      end
      ST_RACK: begin
        sda_oe_d = ~rd_nack_d;
        scl_oe_d = data_scl_oe(quarter_d);
      end
      default: ;
    endcase
  end

  assign sda_oe    = sda_oe_q;
  assign scl_oe    = scl_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed bench for i2c_master_engine (DIV=4) with a wired-AND slave model on
// SDA/SCL; expected values are hand-computed per transaction.
module tb_i2c_master_engine;

  localparam int DIV     = 4;
  localparam int BIT_CYC = 4 * DIV;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       rd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       sda_in;
  logic       scl_in;
  logic       sda_oe;
  logic       scl_oe;
  logic       slave_sda;
  logic       slave_scl_low;

  int compare_cnt = 0;
  int fail_cnt    = 0;

  int         lat;
  int         rsp_cnt;
  int         rsp_cycle;
  logic       rsp_nack_seen;
  logic [7:0] rsp_data_seen;
  logic [8:0] capture;
  logic       sda_oe_9th;
  logic       sda_fell;
  logic       sda_rose;
  logic       busy_m1;
  logic       ready_m1;
  logic       op_done;
  int         pulses;

  assign sda_in = !sda_oe && slave_sda;
  assign scl_in = !scl_oe && !slave_scl_low;

  i2c_master_engine #(
    .DIV(DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .wr_data  (wr_data),
    .rd_nack  (rd_nack),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_nack (rsp_nack),
    .busy     (busy),
    .sda_in   (sda_in),
    .scl_in   (scl_in),
    .sda_oe   (sda_oe),
    .scl_oe   (scl_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compare_cnt++;
    assert (observed === expected)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one command, then watches the bus until the engine is idle again.
  // pat is what the slave puts on SDA per bit slot (MSB = first bit, 1 = release).
  task automatic apply_stimulus(input logic [1:0] c, input logic [7:0] wd, input logic rn,
                                input logic [8:0] pat, input int stretch_len);
    int   m;
    int   n;
    int   n_capt;
    int   stretch_left;
    logic stretched;
    logic prev_sda;
    logic prev_scl;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    wr_data   = wd;
    rd_nack   = rn;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = ~c;
    wr_data   = ~wd;
    rd_nack   = ~rn;
    m = 0; n_capt = 0; stretch_left = 0; stretched = 1'b0;
    lat = -1; rsp_cnt = 0; rsp_cycle = -1; rsp_nack_seen = 1'bx; rsp_data_seen = 'x;
    capture = '0; sda_oe_9th = 1'bx; sda_fell = 1'b0; sda_rose = 1'b0; op_done = 1'b0;
    prev_sda = sda_in;
    prev_scl = scl_in;
    while (!op_done && m < 400) begin
      @(negedge clk);
      m++;
      if (m == 1) begin
        busy_m1  = busy;
        ready_m1 = cmd_ready;
      end
      if (scl_in && !prev_scl) begin
        capture = {capture[7:0], sda_in};
        n_capt++;
        if (n_capt == 9) sda_oe_9th = sda_oe;
      end
      if (scl_in && prev_scl && prev_sda && !sda_in) sda_fell = 1'b1;
      if (scl_in && prev_scl && !prev_sda && sda_in) sda_rose = 1'b1;
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cycle     = m - 1;
        rsp_nack_seen = rsp_nack;
        rsp_data_seen = rsp_data;
      end
      if (!busy) begin
        lat     = m - 1;
        op_done = 1'b1;
      end
      prev_sda = sda_in;
      prev_scl = scl_in;
      n = (m - 1) / BIT_CYC;
      if (n > 8) n = 8;
      slave_sda = pat[8-n];
      if (!stretched && stretch_len > 0 && !scl_oe) begin
        stretched    = 1'b1;
        stretch_left = stretch_len;
      end
      if (stretch_left > 0) begin
        slave_scl_low = 1'b1;
        stretch_left--;
      end else begin
        slave_scl_low = 1'b0;
      end
    end
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    slave_sda     = 1'b1;
    slave_scl_low = 1'b0;
    check_output("op_completes", op_done, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd           = 2'd0;
    wr_data       = 8'h00;
    rd_nack       = 1'b0;
    slave_sda     = 1'b1;
    slave_scl_low = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_sda_oe", sda_oe, 1'b0);
    check_output("rst_scl_oe", scl_oe, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_rsp_valid", rsp_valid, 1'b0);
    check_output("rst_rsp_data", rsp_data, 8'h00);
    check_output("rst_rsp_nack", rsp_nack, 1'b0);
    check_output("rst_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_output("post_rst_cmd_ready", cmd_ready, 1'b1);

    $display("[TB] START");
    apply_stimulus(2'd0, 8'h00, 1'b0, 9'h1FF, 0);
    check_output("start_latency", lat, 16);
    check_output("start_busy_m1", busy_m1, 1'b1);
    check_output("start_ready_m1", ready_m1, 1'b0);
    check_output("start_sda_fall_scl_high", sda_fell, 1'b1);
    check_output("start_scl_oe_end", scl_oe, 1'b1);
    check_output("start_sda_oe_end", sda_oe, 1'b1);
    check_output("start_no_rsp", rsp_cnt, 0);

    $display("[TB] WRITE 0xA5 with ACK");
    apply_stimulus(2'd2, 8'hA5, 1'b0, 9'b1111_1111_0, 0);
    check_output("wr_a5_bits", capture, {8'hA5, 1'b0});
    check_output("wr_a5_rsp_cycle", rsp_cycle, 144);
    check_output("wr_a5_latency", lat, 144);
    check_output("wr_a5_rsp_nack", rsp_nack_seen, 1'b0);
    check_output("wr_a5_rsp_pulses", rsp_cnt, 1);
    check_output("wr_a5_rsp_data_held", rsp_data_seen, 8'h00);
    check_output("wr_a5_ack_released", sda_oe_9th, 1'b0);
    check_output("wr_a5_scl_low_end", scl_oe, 1'b1);

    $display("[TB] STOP");
    apply_stimulus(2'd1, 8'h00, 1'b0, 9'h1FF, 0);
    check_output("stop_latency", lat, 16);
    check_output("stop_sda_rise_scl_high", sda_rose, 1'b1);
    check_output("stop_sda_oe", sda_oe, 1'b0);
    check_output("stop_scl_oe", scl_oe, 1'b0);
    check_output("stop_cmd_ready", cmd_ready, 1'b1);

    $display("[TB] WRITE 0x3C, no slave");
    apply_stimulus(2'd0, 8'h00, 1'b0, 9'h1FF, 0);
    apply_stimulus(2'd2, 8'h3C, 1'b0, 9'h1FF, 0);
    check_output("wr_3c_bits", capture, {8'h3C, 1'b1});
    check_output("wr_3c_rsp_nack", rsp_nack_seen, 1'b1);
    check_output("wr_3c_rsp_pulses", rsp_cnt, 1);

    $display("[TB] READ 0x5A with NACK");
    apply_stimulus(2'd3, 8'h00, 1'b1, {8'h5A, 1'b1}, 0);
    check_output("rd_5a_data", rsp_data_seen, 8'h5A);
    check_output("rd_5a_rsp_nack", rsp_nack_seen, 1'b1);
    check_output("rd_5a_bus_bits", capture, {8'h5A, 1'b1});
    check_output("rd_5a_9th_released", sda_oe_9th, 1'b0);
    check_output("rd_5a_latency", lat, 144);

    $display("[TB] READ 0xC3 with ACK");
    apply_stimulus(2'd3, 8'h00, 1'b0, {8'hC3, 1'b1}, 0);
    check_output("rd_c3_data", rsp_data_seen, 8'hC3);
    check_output("rd_c3_rsp_nack", rsp_nack_seen, 1'b0);
    check_output("rd_c3_bus_bits", capture, {8'hC3, 1'b0});
    check_output("rd_c3_9th_driven", sda_oe_9th, 1'b1);

    $display("[TB] WRITE 0x81 keeps last read data");
    apply_stimulus(2'd2, 8'h81, 1'b0, 9'h1FF, 0);
    check_output("wr_81_bits", capture, {8'h81, 1'b1});
    check_output("wr_81_rsp_data_held", rsp_data_seen, 8'hC3);
    check_output("wr_81_rsp_nack", rsp_nack_seen, 1'b1);

    apply_stimulus(2'd1, 8'h00, 1'b0, 9'h1FF, 0);
    check_output("stop2_released", {sda_oe, scl_oe}, 2'b00);

    $display("[TB] WRITE with 10-cycle slave clock stretch");
    apply_stimulus(2'd0, 8'h00, 1'b0, 9'h1FF, 0);
    apply_stimulus(2'd2, 8'h3C, 1'b0, 9'h1FF, 10);
`ifdef I2C_CLOCK_STRETCH_EN
    check_output("stretch_latency", lat, 154);
`else
    check_output("stretch_latency", lat, 144);
`endif
    check_output("stretch_rsp_pulses", rsp_cnt, 1);
    check_output("stretch_rsp_nack", rsp_nack_seen, 1'b1);

    $display("[TB] reset during WRITE bit 3");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = 2'd2;
    wr_data   = 8'hA5;
    rd_nack   = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (66) @(negedge clk);
    check_output("midwr_pre_sda_oe", sda_oe, 1'b1);
    check_output("midwr_pre_scl_oe", scl_oe, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midwr_rst_sda_oe", sda_oe, 1'b0);
    check_output("midwr_rst_scl_oe", scl_oe, 1'b0);
    check_output("midwr_rst_busy", busy, 1'b0);
    check_output("midwr_rst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (160) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check_output("midwr_no_rsp", pulses, 0);
    check_output("midwr_ready_after", cmd_ready, 1'b1);
    check_output("midwr_lines_released", {sda_in, scl_in}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule
